// File: rtl/mem_pwr_seq.sv
// SRAM power sequencer: isolation-before-cut, release-after-restore and
// staggered bank power-up driven by the sleep controller's gate/sleep requests.
module mem_pwr_seq #(
  parameter int unsigned N_SMALL        = 2,
  parameter int unsigned N_LARGE        = 4,
  parameter int unsigned STAGGER_CYCLES = 16,
  parameter int unsigned ISO_CYCLES     = 2
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       mem_sleep_i,
  input  logic                       mem_gate_small_i,
  input  logic                       mem_gate_large_i,
  output logic [N_SMALL+N_LARGE-1:0] mem_pwr_en_o,
  output logic                       mem_iso_o,
  output logic                       mem_ret_o,
  output logic                       mem_ready_o,
  output logic                       busy_o
);

  localparam int unsigned NB      = N_SMALL + N_LARGE;
  localparam int unsigned CNT_MAX = (STAGGER_CYCLES > ISO_CYCLES) ? STAGGER_CYCLES : ISO_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER_CYCLES - 1);
  localparam logic [CW-1:0] ISO_LAST  = CW'(ISO_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_ON,
    ST_ISO_WAIT,
    ST_STEADY,
    ST_RAMP,
    ST_REL_WAIT
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [NB-1:0]   pwr_q, pwr_d;
  logic            iso_q, iso_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            ret_q;

  logic [NB-1:0]   tgt;
  logic [NB-1:0]   pwr_kept;
  logic [NB-1:0]   cand;
  logic [NB-1:0]   nxt_oh;
  logic            found;
  logic            req;

  assign tgt      = {{N_LARGE{~mem_gate_large_i}}, {N_SMALL{~mem_gate_small_i}}};
  assign pwr_kept = pwr_q & tgt;
  assign cand     = ~pwr_q & tgt;
  assign req      = mem_sleep_i | mem_gate_small_i | mem_gate_large_i;
  assign cnt_inc  = cnt_q + CW'(1);

  // Lowest-index bank that should be on but is currently off.
  always_comb begin
    nxt_oh = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (cand[i] && !found) begin
        nxt_oh[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pwr_d   = pwr_q;
    unique case (state_q)
      ST_ON: begin
        pwr_d = '1;
        if (req) begin
          state_d = ST_ISO_WAIT;
          cnt_d   = '0;
        end
      end
      ST_ISO_WAIT: begin
        if (cnt_q == ISO_LAST) begin
          state_d = ST_STEADY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_STEADY: begin
        pwr_d = pwr_kept;
        if (found) begin
          state_d = ST_RAMP;
          pwr_d   = pwr_kept | nxt_oh;
          cnt_d   = '0;
        end else if ((&pwr_kept) && !mem_sleep_i) begin
          state_d = ST_REL_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RAMP: begin
        // The window after the last bank doubles as the settle period.
        pwr_d = pwr_kept;
        if (cnt_q == STAG_LAST) begin
          cnt_d = '0;
          if (found) begin
            pwr_d = pwr_kept | nxt_oh;
          end else begin
            state_d = ST_STEADY;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_REL_WAIT: begin
        if (req) begin
          state_d = ST_STEADY;
          cnt_d   = '0;
        end else if (cnt_q == ISO_LAST) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_ON;
        cnt_d   = '0;
        pwr_d   = '1;
      end
    endcase
  end

  always_comb begin
    iso_d   = (state_d != ST_ON);
    ready_d = (state_d == ST_ON);
    busy_d  = (state_d == ST_ISO_WAIT) || (state_d == ST_RAMP) || (state_d == ST_REL_WAIT);
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= ST_ON;
      cnt_q   <= '0;
      pwr_q   <= '1;
      iso_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwr_q   <= pwr_d;
      iso_q   <= iso_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      ret_q   <= mem_sleep_i;
    end
  end

  assign mem_pwr_en_o = pwr_q;
  assign mem_iso_o    = iso_q;
  assign mem_ret_o    = ret_q;
  assign mem_ready_o  = ready_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_mem_pwr_seq.sv
// Directed bench for mem_pwr_seq with hand-computed expected bank/iso timing.
module tb_mem_pwr_seq;

  logic       HCLK;
  logic       HRESETn;
  logic       mem_sleep_i;
  logic       mem_gate_small_i;
  logic       mem_gate_large_i;
  logic [5:0] mem_pwr_en_o;
  logic       mem_iso_o;
  logic       mem_ret_o;
  logic       mem_ready_o;
  logic       busy_o;

  int checks;
  int errors;

  mem_pwr_seq #(
    .N_SMALL(2),
    .N_LARGE(4),
    .STAGGER_CYCLES(16),
    .ISO_CYCLES(2)
  ) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .mem_sleep_i(mem_sleep_i),
    .mem_gate_small_i(mem_gate_small_i),
    .mem_gate_large_i(mem_gate_large_i),
    .mem_pwr_en_o(mem_pwr_en_o),
    .mem_iso_o(mem_iso_o),
    .mem_ret_o(mem_ret_o),
    .mem_ready_o(mem_ready_o),
    .busy_o(busy_o)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Advance one edge; outputs are sampled and inputs driven 1 time unit later.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    mem_sleep_i = 1'b0;
    mem_gate_small_i = 1'b0;
    mem_gate_large_i = 1'b0;
    repeat (3) tick();
    checks++; if (mem_pwr_en_o !== 6'h3F) begin errors++; $display("FAIL reset_pwr got=%h exp=3f", mem_pwr_en_o); end
    checks++; if (mem_iso_o !== 1'b0) begin errors++; $display("FAIL reset_iso got=%b exp=0", mem_iso_o); end
    checks++; if (mem_ret_o !== 1'b0) begin errors++; $display("FAIL reset_ret got=%b exp=0", mem_ret_o); end
    checks++; if (mem_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", mem_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    HRESETn = 1'b1;
    tick();
    checks++; if (mem_ready_o !== 1'b1 || mem_pwr_en_o !== 6'h3F) begin errors++; $display("FAIL idle_on got ready=%b pwr=%h exp ready=1 pwr=3f", mem_ready_o, mem_pwr_en_o); end
  endtask

  task automatic test_full_off();
    mem_sleep_i = 1'b1;
    mem_gate_small_i = 1'b1;
    mem_gate_large_i = 1'b1;
    tick(); // T
    checks++; if (mem_ret_o !== 1'b1) begin errors++; $display("FAIL off_ret got=%b exp=1", mem_ret_o); end
    checks++; if (mem_iso_o !== 1'b1) begin errors++; $display("FAIL off_iso got=%b exp=1", mem_iso_o); end
    checks++; if (mem_ready_o !== 1'b0) begin errors++; $display("FAIL off_ready got=%b exp=0", mem_ready_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL off_busy_isowait got=%b exp=1", busy_o); end
    checks++; if (mem_pwr_en_o !== 6'h3F) begin errors++; $display("FAIL off_pwr_T got=%h exp=3f", mem_pwr_en_o); end
    tick(); // T+1
    tick(); // T+2
    checks++; if (mem_pwr_en_o !== 6'h3F) begin errors++; $display("FAIL off_pwr_T2 got=%h exp=3f", mem_pwr_en_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL off_busy_steady got=%b exp=0", busy_o); end
    tick(); // T+3
    checks++; if (mem_pwr_en_o !== 6'h00) begin errors++; $display("FAIL off_pwr_T3 got=%h exp=00", mem_pwr_en_o); end
    checks++; if (mem_iso_o !== 1'b1) begin errors++; $display("FAIL off_iso_T3 got=%b exp=1", mem_iso_o); end
    tick();
    checks++; if (mem_pwr_en_o !== 6'h00 || mem_iso_o !== 1'b1) begin errors++; $display("FAIL off_hold got pwr=%h iso=%b exp pwr=00 iso=1", mem_pwr_en_o, mem_iso_o); end
  endtask

  // Ramp from full off, then release sleep; c counts edges after R.
  task automatic test_ramp_and_release();
    logic [5:0] exp_pwr;
    mem_gate_small_i = 1'b0;
    tick(); // R
    checks++; if (mem_pwr_en_o !== 6'h01) begin errors++; $display("FAIL ramp_R got=%h exp=01", mem_pwr_en_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL ramp_busy got=%b exp=1", busy_o); end
    for (int c = 1; c <= 99; c++) begin
      tick();
      if (c <= 80) begin
        exp_pwr = 6'((7'd1 << (1 + c / 16)) - 7'd1);
        checks++; if (mem_pwr_en_o !== exp_pwr) begin errors++; $display("FAIL ramp_pwr c=%0d got=%h exp=%h", c, mem_pwr_en_o, exp_pwr); end
        checks++; if (mem_iso_o !== 1'b1) begin errors++; $display("FAIL ramp_iso c=%0d got=%b exp=1", c, mem_iso_o); end
      end
      if (c == 5) mem_gate_large_i = 1'b0;
      if (c == 85) mem_sleep_i = 1'b0;
      if (c == 86) begin
        checks++; if (mem_ret_o !== 1'b0) begin errors++; $display("FAIL rel_ret got=%b exp=0", mem_ret_o); end
      end
      if (c == 95) begin
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL settle_busy got=%b exp=1", busy_o); end
      end
      if (c == 96) begin
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL steady_busy got=%b exp=0", busy_o); end
      end
      if (c == 97) begin
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL relwait_busy got=%b exp=1", busy_o); end
      end
      if (c == 98) begin
        checks++; if (mem_iso_o !== 1'b1 || mem_ready_o !== 1'b0) begin errors++; $display("FAIL rel_early got iso=%b ready=%b exp iso=1 ready=0", mem_iso_o, mem_ready_o); end
      end
      if (c == 99) begin
        checks++; if (mem_iso_o !== 1'b0) begin errors++; $display("FAIL rel_iso got=%b exp=0", mem_iso_o); end
        checks++; if (mem_ready_o !== 1'b1) begin errors++; $display("FAIL rel_ready got=%b exp=1", mem_ready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rel_busy got=%b exp=0", busy_o); end
        checks++; if (mem_pwr_en_o !== 6'h3F) begin errors++; $display("FAIL rel_pwr got=%h exp=3f", mem_pwr_en_o); end
      end
    end
  endtask

  task automatic test_midramp_gate();
    mem_gate_small_i = 1'b1;
    mem_gate_large_i = 1'b1;
    repeat (4) tick(); // T+3: all off
    checks++; if (mem_pwr_en_o !== 6'h00) begin errors++; $display("FAIL mg_off got=%h exp=00", mem_pwr_en_o); end
    mem_gate_small_i = 1'b0;
    mem_gate_large_i = 1'b0;
    for (int c = 0; c <= 50; c++) begin
      tick();
      if (c == 32) begin
        checks++; if (mem_pwr_en_o !== 6'h07) begin errors++; $display("FAIL mg_three got=%h exp=07", mem_pwr_en_o); end
        mem_gate_large_i = 1'b1;
      end
      if (c == 33) begin
        checks++; if (mem_pwr_en_o !== 6'h03) begin errors++; $display("FAIL mg_clear got=%h exp=03", mem_pwr_en_o); end
      end
      if (c == 47) begin
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mg_busy47 got=%b exp=1", busy_o); end
      end
      if (c == 48 || c == 50) begin
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mg_steady c=%0d got=%b exp=0", c, busy_o); end
        checks++; if (mem_pwr_en_o !== 6'h03 || mem_iso_o !== 1'b1) begin errors++; $display("FAIL mg_hold c=%0d got pwr=%h iso=%b exp pwr=03 iso=1", c, mem_pwr_en_o, mem_iso_o); end
      end
    end
  endtask

  task automatic test_midramp_reset();
    mem_gate_large_i = 1'b0;
    tick();
    checks++; if (mem_pwr_en_o !== 6'h07 || busy_o !== 1'b1) begin errors++; $display("FAIL mr_ramp got pwr=%h busy=%b exp pwr=07 busy=1", mem_pwr_en_o, busy_o); end
    repeat (5) tick();
    HRESETn = 1'b0;
    tick();
    checks++; if (mem_pwr_en_o !== 6'h3F) begin errors++; $display("FAIL mr_pwr got=%h exp=3f", mem_pwr_en_o); end
    checks++; if (mem_iso_o !== 1'b0 || mem_ready_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL mr_flags got iso=%b ready=%b busy=%b exp 0 1 0", mem_iso_o, mem_ready_o, busy_o); end
    HRESETn = 1'b1;
    tick();
    checks++; if (mem_ready_o !== 1'b1 || mem_pwr_en_o !== 6'h3F) begin errors++; $display("FAIL mr_on got ready=%b pwr=%h exp 1 3f", mem_ready_o, mem_pwr_en_o); end
    // Counter must restart at 0: ISO_WAIT lasts exactly two cycles.
    mem_sleep_i = 1'b1;
    tick(); // T
    checks++; if (busy_o !== 1'b1 || mem_iso_o !== 1'b1) begin errors++; $display("FAIL mr_iso got busy=%b iso=%b exp 1 1", busy_o, mem_iso_o); end
    tick(); // T+1
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mr_isowait1 got=%b exp=1", busy_o); end
    tick(); // T+2
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mr_isowait2 got=%b exp=0", busy_o); end
    checks++; if (mem_pwr_en_o !== 6'h3F) begin errors++; $display("FAIL mr_sleep_pwr got=%h exp=3f", mem_pwr_en_o); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_full_off();
    test_ramp_and_release();
    test_midramp_gate();
    test_midramp_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
